// File: rtl/adc_sample_scheduler_if.sv
// Signal bundle joining the ADC sample scheduler to the serial ADC receiver and the
// downstream sample consumer.
interface adc_sample_scheduler_if;
  logic        enable;
  logic        clr_err;
  logic        rx_done_tick;
  logic        en_temp;
  logic [11:0] data_in;
  logic        rx_en;
  logic        temp_finish;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  // Handshake: there is no ready/back-pressure anywhere. rx_en and temp_finish are
  // one-cycle request pulses to the receiver; rx_done_tick is a valid strobe that
  // qualifies data_in on that same cycle; avg_valid is a valid strobe that qualifies
  // avg_out for one cycle, and the consumer must take it on that cycle.
  modport master (
    input  enable, clr_err, rx_done_tick, en_temp, data_in,
    output rx_en, temp_finish, avg_out, avg_valid, busy, overrun, timeout_err, state_dbg
  );

  modport slave (
    output enable, clr_err, rx_done_tick, en_temp, data_in,
    input  rx_en, temp_finish, avg_out, avg_valid, busy, overrun, timeout_err, state_dbg
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Periodic conversion sequencer for the serial ADC receiver: request, wait, guard hold,
// release, plus block averaging of 2^LOG2_AVG samples with overrun/timeout flags.
module adc_sample_scheduler #(
  parameter int PERIOD   = 40,
  parameter int HOLD_CYC = 2,
  parameter int LOG2_AVG = 2,
  parameter int TIMEOUT  = 32
) (
  input  logic                   SCLK,
  input  logic                   reset,
  adc_sample_scheduler_if.master bus
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int AW = 12 + LOG2_AVG;
  localparam int SW = LOG2_AVG + 1;

  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   per_cnt_q, per_cnt_d;
  logic            tick_q, tick_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   smp_cnt_q, smp_cnt_d;
  logic [11:0]     avg_out_q, avg_out_d;
  logic            avg_valid_q, avg_valid_d;
  logic            rx_en_q, rx_en_d;
  logic            temp_finish_q, temp_finish_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;

  logic [AW-1:0]   acc_sum;
  logic            overrun_set;
  logic            timeout_set;

  // Period counter; the tick is registered so the request lands two cycles after it.
  always_comb begin
    per_cnt_d = '0;
    if (bus.enable) begin
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
    end
    tick_d = bus.enable && (per_cnt_q == PER_LAST);
  end

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    acc_d         = acc_q;
    smp_cnt_d     = smp_cnt_q;
    avg_out_d     = avg_out_q;
    avg_valid_d   = 1'b0;
    temp_finish_d = 1'b0;
    timeout_set   = 1'b0;
    acc_sum       = acc_q + AW'(bus.data_in);

    case (state_q)
      S_IDLE: begin
        // A partial average never survives a pause in sampling.
        if (!bus.enable) begin
          acc_d     = '0;
          smp_cnt_d = '0;
        end else if (tick_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.rx_done_tick) begin
          hold_cnt_d = '0;
          state_d    = S_HOLD;
          if (smp_cnt_q == SMP_LAST) begin
            avg_out_d   = acc_sum[AW-1:LOG2_AVG];
            avg_valid_d = 1'b1;
            acc_d       = '0;
            smp_cnt_d   = '0;
          end else begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Lost frame: release the receiver anyway and restart the average.
          timeout_set   = 1'b1;
          acc_d         = '0;
          smp_cnt_d     = '0;
          temp_finish_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          temp_finish_d = !bus.en_temp;
          state_d       = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    overrun_set   = tick_q && (state_q != S_IDLE);
    rx_en_d       = (state_d == S_START);
    busy_d        = (state_d != S_IDLE);
    overrun_d     = overrun_set || (overrun_q && !bus.clr_err);
    timeout_err_d = timeout_set || (timeout_err_q && !bus.clr_err);
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      per_cnt_q     <= '0;
      tick_q        <= 1'b0;
      tmo_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      acc_q         <= '0;
      smp_cnt_q     <= '0;
      avg_out_q     <= '0;
      avg_valid_q   <= 1'b0;
      rx_en_q       <= 1'b0;
      temp_finish_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      tick_q        <= tick_d;
      tmo_cnt_q     <= tmo_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      acc_q         <= acc_d;
      smp_cnt_q     <= smp_cnt_d;
      avg_out_q     <= avg_out_d;
      avg_valid_q   <= avg_valid_d;
      rx_en_q       <= rx_en_d;
      temp_finish_q <= temp_finish_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.rx_en       = rx_en_q;
  assign bus.temp_finish = temp_finish_q;
  assign bus.avg_out     = avg_out_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.state_dbg   = state_q;

endmodule
